// File: rtl/dht11_pkg.sv
// Shared DHT11 protocol definitions: FSM states, frame size and default timing (1 cycle = 1 us).
// The timing constants are also used by the host reader.
`timescale 1ns/1ps
package dht11_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_REL,
      RESP_DELAY,
      RESP_LOW,
      RESP_HIGH,
      BIT_LOW,
      BIT_HIGH,
      END_LOW
   } dht11_state_t;

   localparam int unsigned FRAME_BITS = 40;

   localparam int unsigned DEF_T_START_MIN  = 18000;
   localparam int unsigned DEF_T_RESP_DELAY = 30;
   localparam int unsigned DEF_T_RESP_LOW   = 80;
   localparam int unsigned DEF_T_RESP_HIGH  = 80;
   localparam int unsigned DEF_T_BIT_LOW    = 50;
   localparam int unsigned DEF_T_ZERO_HIGH  = 26;
   localparam int unsigned DEF_T_ONE_HIGH   = 70;
   localparam int unsigned DEF_T_END_LOW    = 50;

   // 8-bit wrapping sum of the four data bytes.
   function automatic logic [7:0] dht11_checksum(input logic [31:0] i_data);
      logic [7:0] w_sum;
      w_sum = i_data[31:24] + i_data[23:16] + i_data[15:8] + i_data[7:0];
      return w_sum;
   endfunction

endpackage

// File: rtl/dht11_od_pad.sv
// Open-drain pad: pulls the shared line low or leaves it floating; the pull-up is external.
`timescale 1ns/1ps
module dht11_od_pad (
   input  logic i_drive_low,
   inout  wire  io_pin,
   output logic o_raw
);

   assign io_pin = i_drive_low ? 1'b0 : 1'bz;
   assign o_raw  = io_pin;

endmodule

// File: rtl/dht11_responder.sv
// Sensor side of the DHT11 single-wire protocol: qualifies the host start pulse, answers with
// the preamble and shifts out {data_in, checksum} MSB first on an open-drain line.
`timescale 1ns/1ps
module dht11_responder
   import dht11_pkg::*;
#(
   parameter int unsigned T_START_MIN  = DEF_T_START_MIN,
   parameter int unsigned T_RESP_DELAY = DEF_T_RESP_DELAY,
   parameter int unsigned T_RESP_LOW   = DEF_T_RESP_LOW,
   parameter int unsigned T_RESP_HIGH  = DEF_T_RESP_HIGH,
   parameter int unsigned T_BIT_LOW    = DEF_T_BIT_LOW,
   parameter int unsigned T_ZERO_HIGH  = DEF_T_ZERO_HIGH,
   parameter int unsigned T_ONE_HIGH   = DEF_T_ONE_HIGH,
   parameter int unsigned T_END_LOW    = DEF_T_END_LOW
) (
   input  logic        clk_1mhz,
   input  logic        rst_n,
   inout  wire         sensor_pin,
   input  logic [31:0] data_in,
   output logic        busy,
   output logic        done,
   output logic        start_err
);

   localparam int unsigned CNT_W = $clog2(T_START_MIN + 1);
   localparam int unsigned BIT_W = $clog2(FRAME_BITS);

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [BIT_W-1:0] bidx_t;

   localparam cnt_t  C_START_MIN  = cnt_t'(T_START_MIN);
   localparam cnt_t  C_RESP_DELAY = cnt_t'(T_RESP_DELAY - 1);
   localparam cnt_t  C_RESP_LOW   = cnt_t'(T_RESP_LOW - 1);
   localparam cnt_t  C_RESP_HIGH  = cnt_t'(T_RESP_HIGH - 1);
   localparam cnt_t  C_BIT_LOW    = cnt_t'(T_BIT_LOW - 1);
   localparam cnt_t  C_ZERO_HIGH  = cnt_t'(T_ZERO_HIGH - 1);
   localparam cnt_t  C_ONE_HIGH   = cnt_t'(T_ONE_HIGH - 1);
   localparam cnt_t  C_END_LOW    = cnt_t'(T_END_LOW - 1);
   localparam bidx_t C_LAST_BIT   = bidx_t'(FRAME_BITS - 1);

   dht11_state_t          r_state;
   cnt_t                  r_cnt;
   bidx_t                 r_bit_idx;
   logic [FRAME_BITS-1:0] r_shreg;
   logic [1:0]            r_sync;
   logic                  r_drive_low;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_start_err;

   logic                  w_pin_raw;
   logic                  w_line;
   cnt_t                  w_limit;
   logic                  w_phase_end;

   dht11_od_pad u_pad (
      .i_drive_low (r_drive_low),
      .io_pin      (sensor_pin),
      .o_raw       (w_pin_raw)
   );

   // Our own low drive is masked so the tail of END_LOW never looks like a new host start.
   assign w_line = r_sync[1];

   always_comb begin
      w_limit = '0;
      case (r_state)
         RESP_DELAY: w_limit = C_RESP_DELAY;
         RESP_LOW:   w_limit = C_RESP_LOW;
         RESP_HIGH:  w_limit = C_RESP_HIGH;
         BIT_LOW:    w_limit = C_BIT_LOW;
         BIT_HIGH:   w_limit = r_shreg[FRAME_BITS-1] ? C_ONE_HIGH : C_ZERO_HIGH;
         END_LOW:    w_limit = C_END_LOW;
         default:    w_limit = '0;
      endcase
   end

   assign w_phase_end = (r_cnt == w_limit);

   always_ff @(posedge clk_1mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shreg     <= '0;
         r_sync      <= 2'b11;
         r_drive_low <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_start_err <= 1'b0;
      end else begin
         r_sync      <= {r_sync[0], w_pin_raw | r_drive_low};
         r_drive_low <= (r_state == RESP_LOW) || (r_state == BIT_LOW) || (r_state == END_LOW);
         r_done      <= 1'b0;
         r_start_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_line) begin
                  r_cnt   <= '0;
                  r_state <= WAIT_REL;
               end
            end
            WAIT_REL: begin
               if (!w_line) begin
                  if (r_cnt < C_START_MIN) r_cnt <= r_cnt + 1'b1;
               end else if (r_cnt >= C_START_MIN) begin
                  r_shreg   <= {data_in, dht11_checksum(data_in)};
                  r_bit_idx <= '0;
                  r_cnt     <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= RESP_DELAY;
               end else begin
                  r_start_err <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            RESP_DELAY: begin
               r_cnt <= w_phase_end ? '0 : r_cnt + 1'b1;
               if (w_phase_end) r_state <= RESP_LOW;
            end
            RESP_LOW: begin
               r_cnt <= w_phase_end ? '0 : r_cnt + 1'b1;
               if (w_phase_end) r_state <= RESP_HIGH;
            end
            RESP_HIGH: begin
               r_cnt <= w_phase_end ? '0 : r_cnt + 1'b1;
               if (w_phase_end) r_state <= BIT_LOW;
            end
            BIT_LOW: begin
               r_cnt <= w_phase_end ? '0 : r_cnt + 1'b1;
               if (w_phase_end) r_state <= BIT_HIGH;
            end
            BIT_HIGH: begin
               r_cnt <= w_phase_end ? '0 : r_cnt + 1'b1;
               if (w_phase_end) begin
                  r_shreg   <= {r_shreg[FRAME_BITS-2:0], 1'b0};
                  r_bit_idx <= r_bit_idx + 1'b1;
                  r_state   <= (r_bit_idx == C_LAST_BIT) ? END_LOW : BIT_LOW;
               end
            end
            END_LOW: begin
               r_cnt <= w_phase_end ? '0 : r_cnt + 1'b1;
               if (w_phase_end) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign start_err = r_start_err;

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: a host model issues start pulses and queues the expected 40-bit
// words; a reader process decodes the line, checks timing and pops the scoreboard per frame.
`timescale 1ns/1ps
module tb_dht11_responder;
   import dht11_pkg::*;

   // Shortened start qualification keeps the run short; all other timing is default.
   localparam int unsigned T_START  = 200;
   localparam int          LOW_OK   = 201;
   localparam int          LOW_BAD  = 170;
   localparam int          EXP_DLY  = 34;  // 30 delay + 2 sync + 1 decision + 1 drive register

   logic        clk_1mhz = 1'b0;
   logic        rst_n    = 1'b0;
   logic [31:0] data_in  = '0;
   logic        host_low = 1'b0;
   wire         sensor_pin;
   logic        busy, done, start_err;

   int n_vec = 0, n_err = 0;
   int n_release = 0, n_served = 0;
   int n_done_cyc = 0, n_serr_cyc = 0, n_busy_cyc = 0, n_dut_low = 0;
   int busy_drop = 0;
   logic [39:0] sb_q[$];

   pullup (sensor_pin);
   assign sensor_pin = host_low ? 1'b0 : 1'bz;

   always #5 clk_1mhz = ~clk_1mhz;

   dht11_responder #(.T_START_MIN(T_START)) u_dut (
      .clk_1mhz   (clk_1mhz),
      .rst_n      (rst_n),
      .sensor_pin (sensor_pin),
      .data_in    (data_in),
      .busy       (busy),
      .done       (done),
      .start_err  (start_err)
   );

   function automatic logic line_lvl();
      return (sensor_pin === 1'b0) ? 1'b0 : 1'b1;
   endfunction

   task automatic check(input string name, input longint got, input longint exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   always @(negedge clk_1mhz) begin
      if (done) n_done_cyc <= n_done_cyc + 1;
      if (start_err) n_serr_cyc <= n_serr_cyc + 1;
      if (busy) n_busy_cyc <= n_busy_cyc + 1;
      if (!line_lvl() && !host_low) n_dut_low <= n_dut_low + 1;
   end

   // Counts consecutive negedge samples at level lvl, starting at the current negedge.
   task automatic measure(input logic lvl, input bit chk_busy, output int len);
      len = 0;
      while (line_lvl() == lvl && len < 400) begin
         if (chk_busy && !busy) busy_drop++;
         len++;
         @(negedge clk_1mhz);
      end
   endtask

   initial begin : reader
      int d, pl, ph, el, len, tbad, done0;
      logic [39:0] word, exp_w;
      forever begin
         wait (n_release > n_served);
         @(negedge clk_1mhz);
         busy_drop = 0;
         tbad      = 0;
         word      = '0;
         done0     = n_done_cyc;
         measure(1'b1, 1'b0, d);
         measure(1'b0, 1'b1, pl);
         measure(1'b1, 1'b1, ph);
         for (int b = 0; b < 40; b++) begin
            measure(1'b0, 1'b1, len);
            if (len != 50) tbad++;
            measure(1'b1, 1'b1, len);
            word = {word[38:0], (len > 48)};
            if (len != ((len > 48) ? 70 : 26)) tbad++;
         end
         measure(1'b0, 1'b0, el);
         check("resp_delay", d, EXP_DLY);
         check("pre_low", pl, 80);
         check("pre_high", ph, 80);
         check("bit_timing_errs", tbad, 0);
         check("end_low", el, 50);
         check("busy_in_frame", busy_drop, 0);
         check("done_pulse", n_done_cyc - done0, 1);
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_word: got 0x%0h, expected nothing queued", word);
         end else begin
            exp_w = sb_q.pop_front();
            check("frame_word", word, exp_w);
         end
         n_served++;
      end
   end

   task automatic host_start(input int low_cyc, input logic [31:0] d, input logic [39:0] exp_w,
                             input bit frame);
      data_in = d;
      @(posedge clk_1mhz);
      #1 host_low = 1'b1;
      repeat (low_cyc) @(posedge clk_1mhz);
      #1 host_low = 1'b0;
      if (frame) begin
         sb_q.push_back(exp_w);
         n_release++;
      end
   endtask

   task automatic wait_served(input int budget);
      int i;
      i = 0;
      while (n_served != n_release && i < budget) begin
         @(negedge clk_1mhz);
         i++;
      end
      check("frame_complete", (n_served == n_release) ? 1 : 0, 1);
      repeat (20) @(posedge clk_1mhz);
   endtask

   task automatic run_frame(input logic [31:0] d, input logic [39:0] exp_w);
      host_start(LOW_OK, d, exp_w, 1'b1);
      wait_served(8000);
   endtask

   initial begin : watchdog
      #900_000;
      $display("FAIL watchdog: simulation exceeded its cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int e0, l0, b0, d0, falls, i;
      logic prev, cur;

      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_start_err", start_err, 0);
      check("rst_pin_released", line_lvl(), 1);
      repeat (3) @(posedge clk_1mhz);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk_1mhz);

      // Data changed mid-frame must not alter the word already latched.
      host_start(LOW_OK, 32'h37001A05, 40'h37001A0556, 1'b1);
      repeat (10) @(posedge clk_1mhz);
      data_in = 32'h12345678;
      wait_served(8000);

      run_frame(32'hFFFFFF03, 40'hFFFFFF0300);

      e0 = n_serr_cyc;
      l0 = n_dut_low;
      b0 = n_busy_cyc;
      host_start(LOW_BAD, 32'h11223344, '0, 1'b0);
      repeat (60) @(posedge clk_1mhz);
      check("short_start_err", n_serr_cyc - e0, 1);
      check("short_no_drive", n_dut_low - l0, 0);
      check("short_no_busy", n_busy_cyc - b0, 0);

      run_frame(32'hFFFFFFFF, 40'hFFFFFFFFFC);
      run_frame(32'h00000000, 40'h0000000000);

      // Reset during bit 12 low: falls are preamble, then one per bit.
      host_start(LOW_OK, 32'hAAAA5555, '0, 1'b0);
      falls = 0;
      prev  = 1'b1;
      i     = 0;
      while (falls < 14 && i < 3000) begin
         @(negedge clk_1mhz);
         cur = line_lvl();
         if (prev && !cur) falls++;
         prev = cur;
         i++;
      end
      check("bit12_reached", falls, 14);
      repeat (10) @(negedge clk_1mhz);
      check("drive_before_rst", line_lvl(), 0);
      d0 = n_done_cyc;
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_pin_released", line_lvl(), 1);
      check("rst_mid_busy", busy, 0);
      repeat (5) @(posedge clk_1mhz);
      #1 rst_n = 1'b1;
      repeat (100) @(posedge clk_1mhz);
      check("rst_mid_no_done", n_done_cyc - d0, 0);

      run_frame(32'h01020304, 40'h010203040A);

      run_frame(32'h2A003C00, 40'h2A003C0066);
      run_frame(32'h55501234, 40'h55501234EB);
      run_frame(32'h0080FF7F, 40'h0080FF7FFE);

      check("total_done_cycles", n_done_cyc, 8);
      check("scoreboard_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
